// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}; one quotient bit is produced per cycle.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BYZERO, ON, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    // One restoring step: trial-subtract the divisor from the shifted remainder.
    logic [WIDTH+1:0]   diff;
    logic               borrow;
    logic [WIDTH-1:0]   rem_next, quo_next;
    logic               neg1, neg2;
    logic [WIDTH-1:0]   mag1, mag2;

    // Datapath for the current iteration and operand magnitudes at acceptance
    always_comb begin
        diff     = {1'b0, rem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};
        borrow   = diff[WIDTH+1];
        rem_next = borrow ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : diff[WIDTH-1:0];
        quo_next = {dvd_q[WIDTH-2:0], ~borrow};
        neg1     = signed_div_i & opdata1_i[WIDTH-1];
        neg2     = signed_div_i & opdata2_i[WIDTH-1];
        mag1     = neg1 ? -opdata1_i : opdata1_i;
        mag2     = neg2 ? -opdata2_i : opdata2_i;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        cnt_d   = '0;
                        dvd_d   = mag1;
                        dvs_d   = mag2;
                        rem_d   = '0;
                        qsign_d = neg1 ^ neg2;
                        rsign_d = neg1;
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    rem_d = rem_next;
                    dvd_d = quo_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = DONE;
                        result_d = {rsign_q ? -rem_next : rem_next,
                                    qsign_q ? -quo_next : quo_next};
                        ready_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                // annul is ignored here; only dropping start releases the result
                if (!start_i) begin
                    state_d  = IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BYZERO) || (state_d == ON);
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed corner cases plus random divides vs. an arithmetic model.
module tb_div_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i, annul_i, signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] result_o;
    logic        ready_o, busy_o;

    int n_chk = 0;
    int n_pass = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .annul_i(annul_i),
        .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: divide magnitudes, then apply signs; divide-by-zero gives 0.
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q, r;
        logic na, nb;
        logic [31:0] qq, rr;
        if (b == 0) return 64'd0;
        na = sg && a[31];
        nb = sg && b[31];
        ma = na ? (64'h1_0000_0000 - a) : a;
        mb = nb ? (64'h1_0000_0000 - b) : b;
        q = ma / mb;
        r = ma % mb;
        qq = q[31:0];
        rr = r[31:0];
        if (na ^ nb) qq = -qq;
        if (na) rr = -rr;
        return {rr, qq};
    endfunction

    task automatic run_div(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat, busyc, explat;
        exp = model(sg, a, b);
        explat = (b == 0) ? 1 : 32;
        @(negedge clk);
        start_i = 1'b1; signed_div_i = sg; opdata1_i = a; opdata2_i = b;
        @(negedge clk);
        // operands after acceptance must not matter
        opdata1_i = $urandom; opdata2_i = $urandom;
        lat = 0; busyc = 0;
        while (!ready_o && lat < 100) begin
            lat++;
            if (busy_o) busyc++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 64'(lat), 64'(explat));
        chk({tag, " busy_cycles"}, 64'(busyc), 64'(explat));
        chk({tag, " result"}, result_o, exp);
        chk({tag, " busy_done"}, {63'd0, busy_o}, 64'd0);
        annul_i = 1'b1;  // ignored in DONE
        @(negedge clk);
        annul_i = 1'b0;
        chk({tag, " hold_ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, " hold_result"}, result_o, exp);
        start_i = 1'b0;
        @(negedge clk);
        chk({tag, " release_ready"}, {63'd0, ready_o}, 64'd0);
        chk({tag, " release_result"}, result_o, 64'd0);
    endtask

    initial begin
        int rdy_seen;
        reset_n = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        chk("reset result", result_o, 64'd0);
        chk("reset ready", {63'd0, ready_o}, 64'd0);
        chk("reset busy", {63'd0, busy_o}, 64'd0);
        reset_n = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        chk("divu_100_7 const", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_div("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7);
        run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
        run_div("div_0_x", 1'b1, 32'd0, 32'hFFFFFFF9);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);

        // start together with annul in IDLE must not accept
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        repeat (3) @(negedge clk);
        chk("annul_idle busy", {63'd0, busy_o}, 64'd0);
        chk("annul_idle ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0; annul_i = 1'b0;

        // annul during iteration 10
        @(negedge clk);
        start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        repeat (10) @(negedge clk);   // now after E9
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul_on busy", {63'd0, busy_o}, 64'd0);
        chk("annul_on ready", {63'd0, ready_o}, 64'd0);
        chk("annul_on result", result_o, 64'd0);
        annul_i = 1'b0; start_i = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rdy_seen++;
        end
        chk("annul_on no_ready", 64'(rdy_seen), 64'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3);

        // reset during iteration 20
        @(negedge clk);
        start_i = 1'b1; signed_div_i = 1'b1; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd13;
        repeat (20) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_reset busy", {63'd0, busy_o}, 64'd0);
        chk("mid_reset ready", {63'd0, ready_o}, 64'd0);
        chk("mid_reset result", result_o, 64'd0);
        reset_n = 1'b0; start_i = 1'b0;
        run_div("post_reset", 1'b1, 32'hDEADBEEF, 32'd13);

        // random mix
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            logic sg;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = b & 32'hFF;
                1: b = 32'd0;
                default: ;
            endcase
            sg = 1'($urandom_range(0, 1));
            run_div($sformatf("rand%0d", i), sg, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
